// File: rtl/read_axi_tracker.sv
// rtl/read_axi_tracker.sv - multi-outstanding AXI read tracker with per-ID ordered rlast generation
// Each slot holds one accepted AR; the head for an ID is the valid same-ID slot with nothing older ahead of it.
module read_axi_tracker #(
    parameter int IDWID = 4,
    parameter int LWID  = 16,
    parameter int BWID  = 4,
    parameter int SLOTS = 4,
    localparam int AWID = $clog2(SLOTS),
    localparam int CWID = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arvalid,
    output logic             arready,
    input  logic [IDWID-1:0] arid,
    input  logic [LWID-1:0]  arbytes,
    input  logic             rvalid,
    input  logic             rready,
    input  logic [IDWID-1:0] rid,
    input  logic [BWID-1:0]  beatbytes,
    output logic             rlast,
    output logic             rhit,
    output logic [CWID-1:0]  outstanding,
    output logic             orphan,
    input  logic             clr_orphan
);

    logic [SLOTS-1:0] valid_q, valid_d;
    logic [IDWID-1:0] id_q     [SLOTS];
    logic [IDWID-1:0] id_d     [SLOTS];
    logic [LWID-1:0]  remain_q [SLOTS];
    logic [LWID-1:0]  remain_d [SLOTS];
    logic [AWID-1:0]  ahead_q  [SLOTS];
    logic [AWID-1:0]  ahead_d  [SLOTS];
    logic [CWID-1:0]  outstanding_q, outstanding_d;
    logic             orphan_q, orphan_d;

    logic             head_any;
    logic [AWID-1:0]  head_idx;
    logic [AWID-1:0]  free_idx;
    logic [AWID-1:0]  new_ahead;
    logic             hit, accept, consume, retire;

    // arready depends only on registered valids; a same-cycle retire never frees a slot for reuse.
    assign arready     = ~&valid_q;
    assign accept      = arvalid && arready;
    assign outstanding = outstanding_q;
    assign orphan      = orphan_q;

    always_comb begin
        head_any = 1'b0;
        head_idx = '0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = AWID'(i);
            if (valid_q[i] && id_q[i] == rid && ahead_q[i] == '0) begin
                head_any = 1'b1;
                head_idx = AWID'(i);
            end
        end
    end

    assign hit     = rvalid && head_any;
    assign rhit    = hit;
    assign rlast   = hit && (LWID'(beatbytes) >= remain_q[head_idx]);
    assign consume = hit && rready;
    assign retire  = consume && rlast;

    always_comb begin
        new_ahead = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_q[i] && id_q[i] == arid && !(retire && AWID'(i) == head_idx))
                new_ahead = new_ahead + AWID'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < SLOTS; i++) begin
            id_d[i]     = id_q[i];
            remain_d[i] = remain_q[i];
            ahead_d[i]  = ahead_q[i];
            if (retire && AWID'(i) == head_idx) begin
                valid_d[i] = 1'b0;
            end else if (retire && valid_q[i] && id_q[i] == rid) begin
                ahead_d[i] = ahead_q[i] - AWID'(1);
            end
            if (consume && !rlast && AWID'(i) == head_idx)
                remain_d[i] = remain_q[i] - LWID'(beatbytes) - LWID'(1);
        end
        if (accept) begin
            valid_d[free_idx]  = 1'b1;
            id_d[free_idx]     = arid;
            remain_d[free_idx] = arbytes;
            ahead_d[free_idx]  = new_ahead;
        end
        outstanding_d = outstanding_q + CWID'(accept) - CWID'(retire);
        // A fresh orphan beat takes priority over a same-cycle clear.
        if (rvalid && rready && !hit) orphan_d = 1'b1;
        else if (clr_orphan)          orphan_d = 1'b0;
        else                          orphan_d = orphan_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            outstanding_q <= '0;
            orphan_q      <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                id_q[i]     <= '0;
                remain_q[i] <= '0;
                ahead_q[i]  <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            outstanding_q <= outstanding_d;
            orphan_q      <= orphan_d;
            for (int i = 0; i < SLOTS; i++) begin
                id_q[i]     <= id_d[i];
                remain_q[i] <= remain_d[i];
                ahead_q[i]  <= ahead_d[i];
            end
        end
    end

endmodule

// File: tb/tb_read_axi_tracker.sv
// tb/tb_read_axi_tracker.sv - bench for read_axi_tracker against an issue-ordered request list model
module tb_read_axi_tracker;

    localparam int SLOTS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [15:0] arbytes;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [3:0]  beatbytes;
    logic        rlast;
    logic        rhit;
    logic [2:0]  outstanding;
    logic        orphan;
    logic        clr_orphan;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: outstanding requests in issue order; the head for an ID is its first entry.
    int q_id[$];
    int q_rem[$];
    bit m_orphan = 1'b0;

    always #5 clk = ~clk;

    read_axi_tracker #(.IDWID(4), .LWID(16), .BWID(4), .SLOTS(SLOTS)) dut (
        .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .arid(arid),
        .arbytes(arbytes), .rvalid(rvalid), .rready(rready), .rid(rid),
        .beatbytes(beatbytes), .rlast(rlast), .rhit(rhit), .outstanding(outstanding),
        .orphan(orphan), .clr_orphan(clr_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int find_head(input int id);
        for (int k = 0; k < q_id.size(); k++)
            if (q_id[k] == id) return k;
        return -1;
    endfunction

    task automatic set(input bit arv, input int ari, input int arb,
                       input bit rv, input bit rr, input int ri, input int bb);
        arvalid   = arv;
        arid      = 4'(ari);
        arbytes   = 16'(arb);
        rvalid    = rv;
        rready    = rr;
        rid       = 4'(ri);
        beatbytes = 4'(bb);
    endtask

    task automatic tick();
        int  k;
        bit  e_hit, e_last, e_ar;
        @(negedge clk);
        k      = find_head(int'(rid));
        e_hit  = rvalid && (k >= 0);
        e_last = e_hit && (int'(beatbytes) >= q_rem[k]);
        e_ar   = q_id.size() < SLOTS;
        chk("arready", 32'(arready), 32'(e_ar));
        chk("rhit", 32'(rhit), 32'(e_hit));
        chk("rlast", 32'(rlast), 32'(e_last));
        chk("outstanding", 32'(outstanding), 32'(q_id.size()));
        chk("orphan", 32'(orphan), 32'(m_orphan));
        @(posedge clk);
        if (rst) begin
            q_id.delete();
            q_rem.delete();
            m_orphan = 1'b0;
        end else begin
            if (rvalid && rready && !e_hit) m_orphan = 1'b1;
            else if (clr_orphan)            m_orphan = 1'b0;
            if (rvalid && rready && e_hit) begin
                if (e_last) begin
                    q_id.delete(k);
                    q_rem.delete(k);
                end else begin
                    q_rem[k] = q_rem[k] - int'(beatbytes) - 1;
                end
            end
            if (arvalid && e_ar) begin
                q_id.push_back(int'(arid));
                q_rem.push_back(int'(arbytes));
            end
        end
        #1;
    endtask

    initial begin
        clr_orphan = 1'b0;
        rst = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();

        // single request, four 16-byte beats
        set(1, 3, 63, 0, 0, 0, 0); tick();
        for (int b = 0; b < 4; b++) begin
            set(0, 0, 0, 1, 1, 3, 15); tick();
        end
        set(0, 0, 0, 0, 0, 0, 0); tick();

        // same-ID ordering
        set(1, 2, 31, 0, 0, 0, 0); tick();
        set(1, 2, 15, 0, 0, 0, 0); tick();
        for (int b = 0; b < 3; b++) begin
            set(0, 0, 0, 1, 1, 2, 15); tick();
        end
        set(0, 0, 0, 0, 0, 0, 0); tick();

        // interleaved IDs
        set(1, 1, 31, 0, 0, 0, 0); tick();
        set(1, 5, 31, 0, 0, 0, 0); tick();
        set(0, 0, 0, 1, 1, 5, 15); tick();
        set(0, 0, 0, 1, 1, 1, 15); tick();
        set(0, 0, 0, 1, 1, 5, 15); tick();
        set(0, 0, 0, 1, 1, 1, 15); tick();
        set(0, 0, 0, 0, 0, 0, 0); tick();

        // full, stall, retire while full
        for (int s = 0; s < SLOTS; s++) begin
            set(1, s, 15, 0, 0, 0, 0); tick();
        end
        set(1, 6, 7, 0, 0, 0, 0); tick();
        for (int s = 0; s < 3; s++) begin
            set(1, 6, 7, 1, 0, 0, 15); tick();
        end
        set(1, 6, 7, 1, 1, 0, 15); tick();
        set(0, 0, 0, 0, 0, 0, 0); tick();
        for (int s = 1; s < SLOTS; s++) begin
            set(0, 0, 0, 1, 1, s, 15); tick();
        end

        // orphan set, clear, and set-beats-clear
        set(0, 0, 0, 1, 1, 7, 3); tick();
        set(0, 0, 0, 0, 0, 0, 0); tick();
        clr_orphan = 1'b1; tick();
        clr_orphan = 1'b0; tick();
        set(0, 0, 0, 1, 1, 7, 3); clr_orphan = 1'b1; tick();
        set(0, 0, 0, 0, 0, 0, 0); tick();
        clr_orphan = 1'b1; tick();
        clr_orphan = 1'b0;

        // a beat for an ID accepted in the same cycle is not yet matchable
        set(1, 9, 15, 1, 1, 9, 15); tick();
        set(0, 0, 0, 1, 1, 9, 15); tick();
        clr_orphan = 1'b1; set(0, 0, 0, 0, 0, 0, 0); tick();
        clr_orphan = 1'b0;

        // same-cycle accept and retire on ID 4, then reset mid-transfer
        set(1, 4, 15, 0, 0, 0, 0); tick();
        set(1, 4, 31, 1, 1, 4, 15); tick();
        set(0, 0, 0, 1, 1, 4, 15); tick();
        set(1, 4, 63, 0, 0, 0, 0); tick();
        rst = 1'b1; set(0, 0, 0, 0, 0, 0, 0); tick();
        rst = 1'b0; tick();

        // randomized traffic with a small ID space to force same-ID overlap
        for (int c = 0; c < 1500; c++) begin
            int ri;
            if (q_id.size() > 0 && $urandom_range(0, 9) < 8)
                ri = q_id[$urandom_range(0, q_id.size() - 1)];
            else
                ri = int'($urandom_range(0, 7));
            set($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ri, int'($urandom_range(0, 15)));
            clr_orphan = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        clr_orphan = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/read_axi_tracker.md
Name: read_axi_tracker

Overview:
- Multi-outstanding successor to the single-request AXI read depot.
- Records up to SLOTS accepted AR requests, each with its ID and byte length.
- Watches the R channel and generates rlast per beat. Same-ID requests are tracked in issue order; different IDs may interleave.
- Sits beside an AXI read master or bridge that lacks native beat counting; flags R beats that match no outstanding request.

Parameters:
- IDWID, 4, width of arid/rid.
- LWID, 16, width of the request byte length (total bytes minus 1).
- BWID, 4, width of the per-beat byte count (bytes in beat minus 1).
- SLOTS, 4, number of outstanding requests tracked (>=2). AWID = clog2(SLOTS), CWID = clog2(SLOTS+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- arvalid  in  1  request present.
- arready  out  1  a free slot exists; combinational from slot valid vector.
- arid  in  IDWID  request ID.
- arbytes  in  LWID  request total bytes minus 1.
- rvalid  in  1  R beat valid.
- rready  in  1  R beat accepted downstream.
- rid  in  IDWID  beat ID.
- beatbytes  in  BWID  bytes in this beat minus 1.
- rlast  out  1  combinational: this beat ends its request.
- rhit  out  1  combinational: rvalid and a head slot matches rid.
- outstanding  out  CWID  registered count of valid slots.
- orphan  out  1  sticky registered error: an accepted beat matched no slot.
- clr_orphan  in  1  clears orphan.

Behaviour:
- Reset (rst=1 at a clk edge): all slots invalid, outstanding=0, orphan=0. Hence arready=1, rlast=0, rhit=0. A reset mid-transfer discards all pending requests with no completion.
- Slot state: valid, id[IDWID], remain[LWID], ahead[AWID]. ahead = number of older valid same-ID slots. The head for an ID is the valid slot with that ID and ahead==0; at most one head exists per ID.
- AR accept: when arvalid && arready, allocate the lowest-index free slot.
  - Next cycle: valid=1, id=arid, remain=arbytes.
  - ahead = count of currently valid slots with id==arid that are not retiring this cycle.
- A slot freed this cycle is not reused this cycle, so arready ignores same-cycle retire. arready is therefore 0 when all slots are full even if one retires.
- A newly accepted request is not matchable until the following cycle.
- Beat match: hit = rvalid && head exists for rid. rhit = hit (independent of rready).
- rlast = hit && (beatbytes zero-extended >= remain of head). rlast=0 whenever hit=0.
- Beat consume (rvalid && rready && hit):
  - If rlast: head slot retires (valid<=0). Every other valid slot with the same id decrements ahead by 1.
  - Otherwise: remain <= remain - beatbytes - 1, computed in LWID bits. No underflow is possible because beatbytes < remain.
- Beat stall (rvalid && !rready): no state change; rlast and rhit are still driven.
- Orphan: rvalid && rready && !hit sets orphan=1 next cycle.
  - clr_orphan=1 clears orphan. A set in the same cycle as clr_orphan wins.
  - An orphan beat does not change any slot.
- outstanding is updated each cycle: +1 on accept, -1 on retire, unchanged when both occur together.
- Simultaneous accept and retire with the same ID: the retiring slot is excluded from the new slot's ahead count. Other slots decrement as usual; the new slot does not decrement.
- Zero-latency path: the arvalid→arready path is combinational only through slot valids; there is no combinational path from the R inputs to arready.

Test Plan:
- Single request: arid=3, arbytes=63; four beats with beatbytes=15, rready=1 → rlast=0,0,0,1; remain goes 47,31,15; outstanding goes 1→0.
- Same-ID ordering: AR id=2 bytes 31, then AR id=2 bytes 15; beats beatbytes=15 → rlast on the 2nd and 3rd beats; the second slot's ahead goes 1→0 after the first retires.
- Interleaved IDs: AR id=1 (31), AR id=5 (31); beats in order rid=5,1,5,1 with beatbytes=15 → rlast on the 3rd and 4th beats, both slots freed.
- Full and stall: fill 4 slots → arready=0. Hold rvalid with rready=0 for 3 cycles → rlast held stable, no state change. Then complete one request → arready=1 on the next cycle.
- Orphan: rvalid=1, rready=1, rid=7 with no id-7 request → rhit=0, rlast=0, orphan=1 next cycle; clr_orphan=1 → orphan=0.
- Same-cycle accept plus retire (same ID 4) and a mid-transfer rst → new slot ahead=0 and matchable next cycle; rst clears outstanding to 0 and arready=1.
